regwrite_arbiter: RTL and testbench

Sequencer and arbiter for the single register-file write port and its destination-address mux. It accepts write-back requests from four sources: the main ALU result, link write for jal/jalr, the stack-pointer update, and late load data. It grants one request at a time in round-robin order and drives the mux select and RegWrite strobe. The select is always stable one cycle before and during the write. It sits between the multicycle control unit and the register-file write-address mux / register bank.

---
 rtl/regwrite_arbiter.sv | 127 ++++++++++++
 tb/tb_regwrite_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// Round-robin sequencer for the single register-file write port: four write-back
// sources share one write strobe, with the address-mux select set up a cycle early.
module regwrite_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       wb_rd_sel,
  input  logic       flush,
  output logic [2:0] controle,
  output logic       reg_write,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [2:0] SEL_RT = 3'b000;
  localparam logic [2:0] SEL_RD = 3'b010;
  localparam logic [2:0] SEL_SP = 3'b011;
  localparam logic [2:0] SEL_RA = 3'b100;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic [2:0] controle_d;
  logic       reg_write_d;
  logic [3:0] grant_d;
  logic       busy_d;
  logic [3:0] cand;
  logic [1:0] start;
  logic [2:0] pick;

  // {found, index} of the first set bit of r at or after s, wrapping 3 -> 0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] s);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = s + i[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [2:0] map_code(input logic [1:0] idx, input logic rd_sel);
    logic [2:0] code;
    case (idx)
      2'd0:    code = rd_sel ? SEL_RD : SEL_RT;
      2'd1:    code = SEL_RA;
      2'd2:    code = SEL_SP;
      default: code = SEL_RT;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    controle_d  = controle;
    reg_write_d = 1'b0;
    grant_d     = 4'b0000;
    busy_d      = 1'b0;
    cand        = req;
    start       = ptr_q;
    // Leaving WRITE, the current winner's req is still up for this edge; exclude it.
    if (state_q == WRITE) begin
      cand  = req & ~(4'b0001 << win_q);
      start = win_q + 2'd1;
    end
    pick = rr_pick(cand, start);

    case (state_q)
      IDLE: begin
        if (pick[2] && !flush) begin
          state_d    = SETUP;
          win_d      = pick[1:0];
          controle_d = map_code(pick[1:0], wb_rd_sel);
          busy_d     = 1'b1;
        end
      end
      SETUP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d     = WRITE;
          reg_write_d = 1'b1;
          grant_d     = 4'b0001 << win_q;
          busy_d      = 1'b1;
        end
      end
      WRITE: begin
        ptr_d = win_q + 2'd1;
        if (pick[2]) begin
          state_d    = SETUP;
          win_d      = pick[1:0];
          controle_d = map_code(pick[1:0], wb_rd_sel);
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      controle  <= SEL_RT;
      reg_write <= 1'b0;
      grant     <= 4'b0000;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      controle  <= controle_d;
      reg_write <= reg_write_d;
      grant     <= grant_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios plus randomized request sets
// checked against a transaction-level round-robin service-order model.
module tb_regwrite_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       wb_rd_sel;
  logic       flush;
  logic [2:0] controle;
  logic       reg_write;
  logic [3:0] grant;
  logic       busy;

  int checks;
  int errors;
  int m_ptr;

  regwrite_arbiter dut (
    .clock(clk), .reset(rst_n), .req(req), .wb_rd_sel(wb_rd_sel), .flush(flush),
    .controle(controle), .reg_write(reg_write), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // First requester in set at or after pointer p, modulo 4.
  function automatic int ref_winner(input logic [3:0] set, input int p);
    for (int k = 0; k < 4; k++)
      if (set[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [2:0] exp_code(input int w, input logic sel);
    case (w)
      0:       return sel ? 3'b010 : 3'b000;
      1:       return 3'b100;
      2:       return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; req = 4'b0; wb_rd_sel = 1'b0; flush = 1'b0;
    step; step;
    checks++;
    if ({controle, reg_write, grant, busy} !== 9'b0) begin
      errors++; $display("FAIL reset_state: got %b expected 000000000", {controle, reg_write, grant, busy});
    end
    rst_n = 1'b1;
    req = 4'b0001;
    step; step;
    checks++;
    if (reg_write !== 1'b1 || grant !== 4'b0001) begin
      errors++; $display("FAIL reset_prewrite: got rw=%b grant=%b expected rw=1 grant=0001", reg_write, grant);
    end
    req = 4'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_write !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_async: got rw=%b grant=%b busy=%b expected all 0", reg_write, grant, busy);
    end
    #3 rst_n = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || controle !== 3'b000) begin
      errors++; $display("FAIL reset_release: got busy=%b rw=%b ctl=%b expected 0 0 000", busy, reg_write, controle);
    end
    m_ptr = 0;
  endtask

  task automatic test_round_robin;
    int exp_order[4] = '{0, 1, 2, 3};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if (reg_write !== 1'b0 || grant !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL rr_setup%0d: got rw=%b grant=%b busy=%b expected 0 0000 1", k, reg_write, grant, busy);
      end
      step;
      checks++;
      if (grant !== (4'b0001 << exp_order[k]) || reg_write !== 1'b1) begin
        errors++; $display("FAIL rr_grant%0d: got grant=%b rw=%b expected grant=%b rw=1", k, grant, reg_write, 4'b0001 << exp_order[k]);
      end
      req[exp_order[k]] = 1'b0;
    end
    m_ptr = 0;
    step;
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL rr_idle: got busy=%b rw=%b expected 0 0", busy, reg_write);
    end
  endtask

  task automatic test_single_rd;
    req = 4'b0001; wb_rd_sel = 1'b1;
    step;
    checks++;
    if (controle !== 3'b010 || reg_write !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_setup: got ctl=%b rw=%b busy=%b expected 010 0 1", controle, reg_write, busy);
    end
    step;
    checks++;
    if (reg_write !== 1'b1 || grant !== 4'b0001 || controle !== 3'b010) begin
      errors++; $display("FAIL single_write: got rw=%b grant=%b ctl=%b expected 1 0001 010", reg_write, grant, controle);
    end
    req = 4'b0; m_ptr = 1;
    step;
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || grant !== 4'b0) begin
      errors++; $display("FAIL single_idle: got busy=%b rw=%b grant=%b expected 0 0 0000", busy, reg_write, grant);
    end
  endtask

  task automatic test_fixed_codes;
    logic [2:0] codes[2] = '{3'b100, 3'b011};
    for (int i = 0; i < 2; i++) begin
      req = 4'b0001 << (i + 1);
      step;
      checks++;
      if (controle !== codes[i] || reg_write !== 1'b0) begin
        errors++; $display("FAIL fixed_setup%0d: got ctl=%b rw=%b expected %b 0", i + 1, controle, reg_write, codes[i]);
      end
      step;
      checks++;
      if (controle !== codes[i] || grant !== (4'b0001 << (i + 1))) begin
        errors++; $display("FAIL fixed_write%0d: got ctl=%b grant=%b expected %b %b", i + 1, controle, grant, codes[i], 4'b0001 << (i + 1));
      end
      req = 4'b0; m_ptr = (i + 2) % 4;
      step;
    end
  endtask

  task automatic test_flush;
    int w;
    req = 4'b1000; flush = 1'b0;
    step;
    flush = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || grant !== 4'b0) begin
      errors++; $display("FAIL flush_setup: got busy=%b rw=%b grant=%b expected 0 0 0000", busy, reg_write, grant);
    end
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got busy=%b expected 0", busy);
    end
    flush = 1'b0;
    step; step;
    checks++;
    if (grant !== 4'b1000 || reg_write !== 1'b1) begin
      errors++; $display("FAIL flush_rearb: got grant=%b rw=%b expected 1000 1", grant, reg_write);
    end
    flush = 1'b1;
    req = 4'b0;
    m_ptr = 0;
    step;
    flush = 1'b0;
    // Pointer must not move on a flushed slot: same winner re-wins.
    req = 4'b0101;
    w = ref_winner(req, m_ptr);
    step; flush = 1'b1;
    step; flush = 1'b0;
    step; step;
    checks++;
    if (grant !== (4'b0001 << w)) begin
      errors++; $display("FAIL flush_rewin: got grant=%b expected %b", grant, 4'b0001 << w);
    end
    flush = 1'b1;
    req = 4'b0;
    m_ptr = (w + 1) % 4;
    step;
    flush = 1'b0;
    step; step;
  endtask

  task automatic test_payload;
    req = 4'b0001; wb_rd_sel = 1'b1;
    step; wb_rd_sel = 1'b0;
    step;
    checks++;
    if (controle !== 3'b010 || grant !== 4'b0001) begin
      errors++; $display("FAIL payload_rd: got ctl=%b grant=%b expected 010 0001", controle, grant);
    end
    req = 4'b0; m_ptr = 1;
    step;
    checks++;
    if (controle !== 3'b010) begin
      errors++; $display("FAIL payload_hold: got ctl=%b expected 010", controle);
    end
    req = 4'b0001; wb_rd_sel = 1'b0;
    step; wb_rd_sel = 1'b1;
    step;
    checks++;
    if (controle !== 3'b000 || reg_write !== 1'b1) begin
      errors++; $display("FAIL payload_rt: got ctl=%b rw=%b expected 000 1", controle, reg_write);
    end
    req = 4'b0;
    step;
  endtask

  task automatic test_random;
    int order[$];
    logic [3:0] tmp;
    logic sel;
    int p, w;
    for (int it = 0; it < 40; it++) begin
      tmp = 4'($urandom_range(1, 15));
      sel = 1'($urandom_range(0, 1));
      order.delete();
      p = m_ptr;
      req = tmp; wb_rd_sel = sel;
      while (tmp != 4'b0) begin
        w = ref_winner(tmp, p);
        order.push_back(w);
        tmp[w] = 1'b0;
        p = (w + 1) % 4;
      end
      foreach (order[k]) begin
        step;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || reg_write !== 1'b0 || grant !== 4'b0 || controle !== exp_code(order[k], sel)) begin
          errors++; $display("FAIL rand_setup it%0d: got busy=%b rw=%b grant=%b ctl=%b expected 1 0 0000 %b", it, busy, reg_write, grant, controle, exp_code(order[k], sel));
        end
        step;
        checks++;
        if (reg_write !== 1'b1 || grant !== (4'b0001 << order[k]) || controle !== exp_code(order[k], sel)) begin
          errors++; $display("FAIL rand_write it%0d: got rw=%b grant=%b ctl=%b expected 1 %b %b", it, reg_write, grant, controle, 4'b0001 << order[k], exp_code(order[k], sel));
        end
        req[order[k]] = 1'b0;
        flush = 1'($urandom_range(0, 1));
        m_ptr = (order[k] + 1) % 4;
      end
      step;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || reg_write !== 1'b0 || grant !== 4'b0) begin
        errors++; $display("FAIL rand_idle it%0d: got busy=%b rw=%b grant=%b expected 0 0 0000", it, busy, reg_write, grant);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ptr  = 0;
    test_reset;
    test_round_robin;
    test_single_rd;
    test_fixed_codes;
    test_flush;
    test_payload;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
